// File: rtl/tournament_chooser.sv
// Tournament choice stage: picks the local or global prediction through a 2-bit choice table indexed by path history.
// Define TOURNAMENT_STATS_EN to add the saturating MispredCount output and the stored final-prediction field.
module tournament_chooser #(
  parameter int GHR_BITS = 12,
  parameter int DEPTH    = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic PredValid,
  input  logic LocalPred,
  input  logic GlobalPred,
  input  logic ResolveValid,
  input  logic BranchTaken,
  output logic BranchResult,
  output logic ResultValid,
  output logic Full
`ifdef TOURNAMENT_STATS_EN
  ,
  output logic [15:0] MispredCount
`endif
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int CT_N = 1 << GHR_BITS;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] v);
    return (v == 2'b00) ? v : v - 2'b01;
  endfunction

  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [1:0]          ct_q [CT_N];
  logic [GHR_BITS-1:0] fifo_idx_q [DEPTH];
  logic                fifo_loc_q [DEPTH];
  logic                fifo_glb_q [DEPTH];
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                full_q, full_d;
  logic                result_q, result_d;
  logic                rvalid_q, rvalid_d;
  logic                push, pop, sel_final;
  logic                ct_we;
  logic [GHR_BITS-1:0] ct_widx;
  logic [1:0]          ct_cur, ct_wval;

`ifdef TOURNAMENT_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        fifo_fin_q [DEPTH];
  logic [15:0] mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if (pop && (fifo_fin_q[head_q] != BranchTaken))
      mis_d = sat_inc16(mis_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mis_q <= 16'd0;
    else        mis_q <= mis_d;
  end

  always_ff @(posedge clock) begin
    if (push) fifo_fin_q[tail_q] <= sel_final;
  end

  assign MispredCount = mis_q;
`endif

  always_comb begin
    // A full queue still accepts when the head retires in the same cycle.
    push      = PredValid && (!full_q || ResolveValid);
    pop       = ResolveValid && (count_q != '0);
    sel_final = ct_q[ghr_q][1] ? GlobalPred : LocalPred;

    head_d   = head_q;
    tail_d   = tail_q;
    ghr_d    = ghr_q;
    result_d = result_q;
    rvalid_d = push;
    ct_widx  = fifo_idx_q[head_q];
    ct_cur   = ct_q[ct_widx];
    ct_we    = 1'b0;
    ct_wval  = ct_cur;

    if (push) begin
      result_d = sel_final;
      tail_d   = PW'(tail_q + 1'b1);
    end
    if (pop) begin
      head_d = PW'(head_q + 1'b1);
      ghr_d  = {ghr_q[GHR_BITS-2:0], BranchTaken};
      // Only train when the two predictors disagreed; exactly one was right.
      if (fifo_loc_q[head_q] != fifo_glb_q[head_q]) begin
        ct_we   = 1'b1;
        ct_wval = (fifo_glb_q[head_q] == BranchTaken) ? sat_inc2(ct_cur) : sat_dec2(ct_cur);
      end
    end

    count_d = count_q + CW'(push) - CW'(pop);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ghr_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      result_q <= 1'b0;
      rvalid_q <= 1'b0;
      for (int i = 0; i < CT_N; i++) ct_q[i] <= 2'b01;
    end else begin
      ghr_q    <= ghr_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      full_q   <= full_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
      if (ct_we) ct_q[ct_widx] <= ct_wval;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_idx_q[tail_q] <= ghr_q;
      fifo_loc_q[tail_q] <= LocalPred;
      fifo_glb_q[tail_q] <= GlobalPred;
    end
  end

  assign BranchResult = result_q;
  assign ResultValid  = rvalid_q;
  assign Full         = full_q;

endmodule

// File: tb/tb_tournament_chooser.sv
// Self-checking bench for tournament_chooser: directed steps plus a biased random phase against a queue-based model.
module tb_tournament_chooser;

  localparam int DEPTH = 8;

  logic clock, reset;
  logic PredValid, LocalPred, GlobalPred, ResolveValid, BranchTaken;
  logic BranchResult, ResultValid, Full;
`ifdef TOURNAMENT_STATS_EN
  logic [15:0] MispredCount;
`endif

  tournament_chooser #(.GHR_BITS(12), .DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .PredValid(PredValid),
    .LocalPred(LocalPred),
    .GlobalPred(GlobalPred),
    .ResolveValid(ResolveValid),
    .BranchTaken(BranchTaken),
    .BranchResult(BranchResult),
    .ResultValid(ResultValid),
    .Full(Full)
`ifdef TOURNAMENT_STATS_EN
    ,
    .MispredCount(MispredCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [11:0] idx;
    logic        l;
    logic        g;
    logic        f;
  } ent_t;

  logic [1:0]  m_ct [4096];
  logic [11:0] m_ghr;
  int          m_mis;
  ent_t        mq [$];
  bit          sb [$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) m_ct[i] = 2'b01;
    m_ghr = '0;
    m_mis = 0;
    mq.delete();
    sb.delete();
  endtask

  // Drives one cycle of stimulus, advances the model, then checks outputs after the edge.
  task automatic step(input bit pv, input bit lp, input bit gp, input bit rv, input bit bt);
    bit   acc;
    bit   fin;
    ent_t e, h;
    PredValid = pv; LocalPred = lp; GlobalPred = gp; ResolveValid = rv; BranchTaken = bt;
    acc = pv && ((mq.size() < DEPTH) || rv);
    fin = m_ct[m_ghr][1] ? gp : lp;
    e   = '{idx: m_ghr, l: lp, g: gp, f: fin};
    if (rv && mq.size() > 0) begin
      h = mq.pop_front();
      if (h.l != h.g) begin
        if (h.g == bt) m_ct[h.idx] = (m_ct[h.idx] == 2'b11) ? 2'b11 : m_ct[h.idx] + 2'b01;
        else           m_ct[h.idx] = (m_ct[h.idx] == 2'b00) ? 2'b00 : m_ct[h.idx] - 2'b01;
      end
      m_ghr = {m_ghr[10:0], bt};
      if (h.f != bt && m_mis < 65535) m_mis++;
    end
    if (acc) begin
      mq.push_back(e);
      sb.push_back(fin);
    end
    @(posedge clock); #1;
    chk("result_valid", 32'(ResultValid), 32'(acc));
    if (ResultValid === 1'b1) begin
      if (sb.size() > 0) chk("branch_result", 32'(BranchResult), 32'(sb.pop_front()));
      else chk("scoreboard_empty", 32'(ResultValid), 32'd0);
    end
    chk("full", 32'(Full), 32'(mq.size() == DEPTH));
`ifdef TOURNAMENT_STATS_EN
    chk("mispred", 32'(MispredCount), 32'(m_mis));
`endif
  endtask

  task automatic do_reset();
    PredValid = 0; LocalPred = 0; GlobalPred = 0; ResolveValid = 0; BranchTaken = 0;
    reset = 1'b0;
    #3;
    chk("rst_result", 32'(BranchResult), 32'd0);
    chk("rst_valid", 32'(ResultValid), 32'd0);
    chk("rst_full", 32'(Full), 32'd0);
`ifdef TOURNAMENT_STATS_EN
    chk("rst_mispred", 32'(MispredCount), 32'd0);
`endif
    model_reset();
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    PredValid = 0; LocalPred = 0; GlobalPred = 0; ResolveValid = 0; BranchTaken = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Weakly-local table picks the local prediction.
    step(1, 1, 0, 0, 0);
    chk("first_pick_local", 32'(BranchResult), 32'd1);
    step(1, 1, 0, 0, 0);
    // Two not-taken resolves train CT[0] 01->10->11 while GHR stays 0.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
`ifdef TOURNAMENT_STATS_EN
    chk("mispred_two", 32'(MispredCount), 32'd2);
`endif
    step(1, 1, 0, 0, 0);
    chk("trained_pick_global", 32'(BranchResult), 32'd0);
    step(0, 0, 0, 1, 0);
    chk("drained_not_full", 32'(Full), 32'd0);

    // Resolve on an empty queue must not shift GHR or touch the table.
    step(0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0);
    chk("empty_resolve_ignored", 32'(BranchResult), 32'd0);
    step(0, 0, 0, 1, 0);

    // Fill the queue, then drop and same-cycle accept at Full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, i[0], i[1], 0, 0);
    chk("full_after_8", 32'(Full), 32'd1);
    step(1, 1, 1, 0, 0);
    chk("dropped_no_valid", 32'(ResultValid), 32'd0);
    step(1, 0, 0, 1, 1);
    chk("accept_at_full_valid", 32'(ResultValid), 32'd1);
    chk("accept_at_full_stays_full", 32'(Full), 32'd1);

    // Reset with five entries in flight.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    do_reset();
    step(1, 1, 0, 0, 0);
    chk("post_reset_local", 32'(BranchResult), 32'd1);
    chk("post_reset_not_full", 32'(Full), 32'd0);

    // Three mispredicted pops, then reset clears the counter.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
`ifdef TOURNAMENT_STATS_EN
    chk("mispred_three", 32'(MispredCount), 32'd3);
`endif
    do_reset();

    // Resolve T, N, T with a prediction alongside the third resolve.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Biased random traffic keeps the history short so table entries get retrained.
    for (int i = 0; i < 800; i++)
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tournament_chooser.md
# tournament_chooser

Choice stage of the tournament branch predictor; sits directly downstream of the local predictor and alongside the global predictor. Each cycle it takes the local and global taken/not-taken predictions for the fetched branch and selects one through a table of 2-bit choice counters indexed by global path history. It queues every accepted prediction until the branch resolves, then trains the choice counter and shifts the path history with the actual outcome.

## Interface
- GHR_BITS, 12, global path-history width; the choice table has 2^GHR_BITS entries.
- DEPTH, 8, in-flight queue entries; power of two, at least 2.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; clears all state while low.
- PredValid  input  1  a local/global prediction pair is presented this cycle.
- LocalPred  input  1  local predictor result (1 = taken).
- GlobalPred  input  1  global predictor result (1 = taken).
- ResolveValid  input  1  oldest in-flight branch resolves this cycle.
- BranchTaken  input  1  actual outcome of the resolving branch.
- BranchResult  output  1  final prediction, registered.
- ResultValid  output  1  BranchResult is valid this cycle.
- Full  output  1  queue holds DEPTH entries.
- MispredCount  output  16  saturating count of final mispredictions (STATS_EN only).

## Operation
- State:
  - GHR, GHR_BITS wide.
  - CT, 2^GHR_BITS × 2-bit counters; MSB = 1 selects global, MSB = 0 selects local.
  - FIFO of {index, LocalPred, GlobalPred, final} with head/tail pointers and a count.
- Accept: push when PredValid && (!Full || ResolveValid). PredValid while Full without ResolveValid is dropped; ResultValid stays 0.
- Select: index = GHR; final = CT[GHR][1] ? GlobalPred : LocalPred. Push {index, LocalPred, GlobalPred, final}.
- Resolve: ResolveValid with count > 0 pops the head and applies, using the head entry:
  - if local != global: saturating increment of CT[index] when global == BranchTaken, saturating decrement when local == BranchTaken;
  - if local == global: CT[index] is unchanged.
  - GHR <= {GHR[GHR_BITS-2:0], BranchTaken}.
- ResolveValid with count == 0 is ignored; no state changes.
- Same-cycle push and pop:
  - the prediction reads the pre-update GHR and CT values;
  - count is unchanged;
  - this is allowed when Full.
- Counters saturate at 2'b00 and 2'b11; pointers wrap modulo DEPTH.
- Reset values:
  - GHR = 0; every CT entry = 2'b01 (weakly local); FIFO empty;
  - BranchResult = 0, ResultValid = 0, Full = 0, MispredCount = 0.
- Reset asserted mid-operation discards all in-flight entries. The first edge after deassertion behaves as from power-up.

## Timing
- Latency 1: a prediction accepted at edge N drives BranchResult and ResultValid = 1 after edge N. ResultValid drops the following cycle unless another prediction is accepted.
- Training and GHR shift take effect at the resolve edge and are visible to a prediction sampled at the next edge.
- Full is registered and reflects the count after the current edge.
- No combinational path from any input to any output.

## Configuration
- TOURNAMENT_STATS_EN defined:
  - MispredCount increments on each pop whose stored final != BranchTaken;
  - it saturates at 16'hFFFF and clears on reset.
- TOURNAMENT_STATS_EN undefined: the MispredCount port is absent, with no counter logic and no final field in queue entries.

## Test plan
- Reset then one prediction (PredValid=1, LocalPred=1, GlobalPred=0) -> BranchResult=1, ResultValid=1 one cycle later; CT[0]=01.
- Same PC pattern, resolve BranchTaken=0 twice with local=1, global=0 and GHR held at 0 by the bench -> CT[0] goes 01→10→11; the next prediction selects global (result 0).
- Push 8 predictions without resolve -> Full=1. A 9th PredValid alone is dropped (ResultValid=0). A 9th with ResolveValid=1 is accepted; Full stays 1.
- ResolveValid on an empty queue -> GHR, CT and count are unchanged.
- Resolve sequence taken, not-taken, taken from reset -> GHR = 12'b101. A prediction in the same cycle as the third resolve uses GHR = 12'b10.
- Assert reset with 5 entries in flight -> queue empty, Full=0, BranchResult=0, all CT entries = 01; with TOURNAMENT_STATS_EN, MispredCount=0 after three mispredicted pops before reset reads 3.
